mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 12, counter width in bits.
REQ-002 Parameter MODULUS, default 4096, count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Parameter PRESCALE, default 1, enabled clocks per count step; legal range >=1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = prescaler and counter advance; 0 = hold all state.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  WIDTH  value loaded on load.
REQ-009 dir  input  1  1 = count up, 0 = count down; sampled at each step.
REQ-010 mode  input  1  0 = wrap (free-running), 1 = one-shot (stop at terminal).
REQ-011 cnt  output  WIDTH  registered count value.
REQ-012 carry  output  1  registered one-cycle pulse on terminal-count step.
REQ-013 done  output  1  registered; 1 while one-shot counter is halted.

Function
REQ-014 Step condition: enable=1, load=0, state RUN, and prescaler count = PRESCALE-1.
REQ-015 Prescaler counts 0..PRESCALE-1 on enabled clocks, wraps to 0 on step, holds when enable=0; PRESCALE=1 means a step on every enabled clock.
REQ-016 Up step: cnt+1; at cnt=MODULUS-1 the step is terminal.
REQ-017 Down step: cnt-1; at cnt=0 the step is terminal.
REQ-018 Terminal step, mode=0: cnt wraps to 0 (up) or MODULUS-1 (down); state stays RUN.
REQ-019 Terminal step, mode=1: cnt holds at terminal value (MODULUS-1 up, 0 down); state goes HALT; done=1 from the next cycle.
REQ-020 carry=1 for exactly the one cycle following a terminal step, in both modes; otherwise 0.
REQ-021 States: RUN (counting), HALT (one-shot expired). RUN->HALT on terminal step with mode=1; HALT->RUN on load; no other transitions.
REQ-022 HALT: cnt, prescaler frozen regardless of enable, dir, mode; carry=0.
REQ-023 load=1 takes priority over stepping and enable: cnt <= load_val, prescaler <= 0, state <= RUN, done <= 0, carry <= 0.
REQ-024 load_val >= MODULUS is clamped to MODULUS-1.
REQ-025 mode change while RUN takes effect at the next terminal step; mode change in HALT does not release HALT.
REQ-026 dir change mid-count takes effect at the next step; no cnt change on the dir change itself.
REQ-027 cnt never leaves 0..MODULUS-1; all arithmetic is modulo MODULUS, not 2^WIDTH.

Reset
REQ-028 reset=1 asynchronously forces cnt=0, prescaler=0, carry=0, done=0, state=RUN, independent of clk.
REQ-029 reset mid-count or in HALT aborts immediately; counting resumes from 0 on the first rising edge after reset deasserts, if enabled.

Verification
REQ-030 MODULUS=10, PRESCALE=1, mode=0, dir=1, enable=1 after reset -> cnt 0..9,0,...; carry=1 only in cycle cnt returns to 0.
REQ-031 MODULUS=10, dir=0, load 3 -> cnt 3,2,1,0,9; carry pulses once with cnt=9.
REQ-032 MODULUS=10, mode=1, dir=1, load 7 -> cnt 7,8,9 then holds 9; carry one cycle; done=1 persists; load 2 -> done=0, counting resumes from 2.
REQ-033 PRESCALE=3, enable toggled 0 for 5 cycles mid-count -> cnt steps every 3 enabled clocks; cnt and prescaler hold while enable=0.
REQ-034 load_val=15 with MODULUS=10 -> cnt=9; load asserted together with a terminal step -> load wins, no carry.
REQ-035 reset asserted between clock edges at cnt=5 -> cnt=0, carry=0, done=0 immediately, before the next edge.

Source files
------------

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with prescaler, wrap or one-shot mode.
// Ports: clk, reset (async high), enable, load, load_val, dir, mode -> cnt, carry, done.
module mod_counter #(
    parameter int WIDTH    = 12,
    parameter int MODULUS  = 4096,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] cnt,
    output logic             carry,
    output logic             done
);

    // Prescaler needs at least one bit even when PRESCALE is 1
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PONE = PW'(1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [PW-1:0]    r_pre;
    logic [PW-1:0]    w_pre_nxt;
    logic             r_carry;
    logic             w_carry_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_run;
    logic             w_step;
    logic             w_term;
    logic [WIDTH-1:0] w_load_clamped;

    // Compare one bit wider so MODULUS == 2^WIDTH never clamps
    assign w_load_clamped = ({1'b0, load_val} >= MODW) ? MAXV : load_val;

    assign w_run  = (r_state == RUN);
    assign w_term = dir ? (r_cnt == MAXV) : (r_cnt == '0);
    assign w_step = enable && !load && w_run && (r_pre == PMAX);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = r_pre;
        w_carry_nxt = 1'b0;

        if (load) begin
            w_cnt_nxt   = w_load_clamped;
            w_pre_nxt   = '0;
            w_state_nxt = RUN;
        end else if (enable && w_run) begin
            w_pre_nxt = (r_pre == PMAX) ? '0 : r_pre + PONE;
            if (w_step) begin
                if (w_term) begin
                    w_carry_nxt = 1'b1;
                    if (mode) begin
                        // One-shot: hold the terminal value
                        w_state_nxt = HALT;
                    end else begin
                        w_cnt_nxt = dir ? '0 : MAXV;
                    end
                end else begin
                    w_cnt_nxt = dir ? r_cnt + ONE : r_cnt - ONE;
                end
            end
        end

        w_done_nxt = (w_state_nxt == HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pre   <= w_pre_nxt;
            r_carry <= w_carry_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign cnt   = r_cnt;
    assign carry = r_carry;
    assign done  = r_done;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (MODULUS=10,
// one instance with PRESCALE=1 and one with PRESCALE=3 sharing inputs).
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       dir = 1'b1;
    logic       mode = 1'b0;
    logic [3:0] cnt;
    logic       carry;
    logic       done;
    logic [3:0] cnt3;
    logic       carry3;
    logic       done3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_val(load_val), .dir(dir), .mode(mode),
        .cnt(cnt), .carry(carry), .done(done)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_val(load_val), .dir(dir), .mode(mode),
        .cnt(cnt3), .carry(carry3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp3 [6];
        int exp_dn [5];
        int car_dn [5];
        exp3   = '{4, 5, 5, 5, 6, 6};
        exp_dn = '{2, 1, 0, 9, 8};
        car_dn = '{0, 0, 0, 1, 0};

        // Asynchronous reset, before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_carry", carry, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt3", cnt3, 0);
        tick();
        tick();
        reset  = 1'b0;
        enable = 1'b1;

        // Up count, wrap mode
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("up_cnt", cnt, k % 10);
            chk("up_carry", carry, (k == 10) ? 1 : 0);
            chk("up_done", done, 0);
            chk("ps3_cnt", cnt3, k / 3);
            chk("ps3_carry", carry3, 0);
        end

        // Disable: everything holds (dut3 prescaler sits at 1)
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_cnt", cnt, 3);
            chk("hold_cnt3", cnt3, 4);
        end

        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("resume_cnt", cnt, 4 + i);
            chk("resume_cnt3", cnt3, exp3[i]);
        end

        // Down count from 3 through the wrap
        dir      = 1'b0;
        load     = 1'b1;
        load_val = 4'd3;
        tick();
        chk("dn_load", cnt, 3);
        chk("dn_load_carry", carry, 0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dn_cnt", cnt, exp_dn[i]);
            chk("dn_carry", carry, car_dn[i]);
        end

        // One-shot up from 7
        mode     = 1'b1;
        dir      = 1'b1;
        load     = 1'b1;
        load_val = 4'd7;
        tick();
        chk("os_load", cnt, 7);
        load = 1'b0;
        tick();
        chk("os_cnt8", cnt, 8);
        tick();
        chk("os_cnt9", cnt, 9);
        chk("os_done_pre", done, 0);
        chk("os_carry_pre", carry, 0);
        tick();
        chk("os_term_cnt", cnt, 9);
        chk("os_term_carry", carry, 1);
        chk("os_term_done", done, 1);
        tick();
        chk("os_halt_cnt", cnt, 9);
        chk("os_halt_carry", carry, 0);
        chk("os_halt_done", done, 1);

        // Mode/dir changes do not release HALT
        mode = 1'b0;
        dir  = 1'b0;
        tick();
        tick();
        chk("halt_mode_cnt", cnt, 9);
        chk("halt_mode_done", done, 1);
        chk("halt_mode_carry", carry, 0);

        mode     = 1'b1;
        dir      = 1'b1;
        load     = 1'b1;
        load_val = 4'd2;
        tick();
        chk("rel_cnt", cnt, 2);
        chk("rel_done", done, 0);
        chk("rel_carry", carry, 0);
        load = 1'b0;
        tick();
        chk("rel_step", cnt, 3);

        // Clamp and load-over-terminal priority
        mode     = 1'b0;
        load     = 1'b1;
        load_val = 4'd15;
        tick();
        chk("clamp_cnt", cnt, 9);
        load_val = 4'd4;
        tick();
        chk("ldprio_cnt", cnt, 4);
        chk("ldprio_carry", carry, 0);

        // Reset between edges at cnt=5
        load_val = 4'd5;
        tick();
        load = 1'b0;
        chk("pre_rst_cnt", cnt, 5);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_carry", carry, 0);
        chk("mid_rst_done", done, 0);
        #2 reset = 1'b0;
        tick();
        chk("post_rst_cnt", cnt, 1);

        // Reset while halted clears done immediately
        mode     = 1'b1;
        load     = 1'b1;
        load_val = 4'd9;
        tick();
        load = 1'b0;
        tick();
        chk("halt2_done", done, 1);
        #3 reset = 1'b1;
        #1;
        chk("halt_rst_done", done, 0);
        chk("halt_rst_cnt", cnt, 0);
        #2 reset = 1'b0;
        mode = 1'b0;
        tick();
        chk("halt_rst_resume", cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
